instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue_if.sv | 26 ++
 rtl/instr_fetch_queue.sv | 136 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Instruction memory bus between the fetch queue and the instruction memory.
// The request channel is valid/ready. The response channel is valid-only and
// returns words in request order.
interface instr_fetch_queue_if;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;

    modport master (
        output Imem_Req_Valid,
        output Imem_Req_Addr,
        input  Imem_Req_Ready,
        input  Imem_Rsp_Valid,
        input  Imem_Rsp_Data
    );

    modport slave (
        input  Imem_Req_Valid,
        input  Imem_Req_Addr,
        output Imem_Req_Ready,
        output Imem_Rsp_Valid,
        output Imem_Rsp_Data
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end that feeds the IF/ID register. It owns the fetch
// PC and issues in-order requests under a credit limit of DEPTH (queued plus
// in flight). Returned words are buffered together with their PC+4. A redirect
// flushes the queue, and the responses that were already in flight are then
// discarded.
//
// Optional feature: define FETCH_BYPASS_EN to present a response word directly
// on the head outputs when the queue is empty.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | first cycle out of reset, no request issued
// S_FETCH | normal operation, requests issued while credits remain
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      Clk,
    input  logic                      Rst,
    instr_fetch_queue_if.master       imem,
    input  logic                      Stall,
    input  logic                      Redirect,
    input  logic [31:0]               Redirect_PC,
    output logic                      Instr_Valid,
    output logic [31:0]               Instr_Out,
    output logic [31:0]               PCplus4_Out,
    output logic [$clog2(DEPTH):0]    Queue_Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]  CREDITS    = (CW+1)'(DEPTH);
    localparam logic [31:0]  RESET_PC_W = RESET_PC & ~32'd3;

    typedef enum logic {S_BOOT, S_FETCH} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;          // PC of the next response that will be kept
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc4   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;

    logic credit_ok, req_fire, rsp_take, rsp_keep, bypass_hit;
    logic head_valid, q_push, q_pop;

    assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < CREDITS;
    assign req_fire  = imem.Imem_Req_Valid && imem.Imem_Req_Ready;
    assign rsp_take  = imem.Imem_Rsp_Valid && (inflight != '0);
    assign rsp_keep  = rsp_take && (discard == '0) && !Redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = rsp_keep && (count == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_valid = ((count != '0) || bypass_hit) && !Redirect;
    assign q_pop      = head_valid && !Stall && (count != '0);
    // A bypassed word that is consumed in the same cycle never enters the queue.
    assign q_push     = rsp_keep && !(bypass_hit && !Stall);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Rst) state <= S_BOOT;
        else      state <= state_nxt;
    end

    // FSM next state: leave BOOT after its single cycle
    always_comb begin
        state_nxt = state;
        if (state == S_BOOT) state_nxt = S_FETCH;
    end

    // FSM outputs: issue a request only in FETCH with credit and no redirect
    always_comb begin
        imem.Imem_Req_Valid = 1'b0;
        if (state == S_FETCH) imem.Imem_Req_Valid = credit_ok && !Redirect;
    end

    // PC, pointer and counter bookkeeping. Redirect overrides normal operation.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fetch_pc <= RESET_PC_W;
            rsp_pc   <= RESET_PC_W;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (Redirect) begin
            fetch_pc <= Redirect_PC & ~32'd3;
            rsp_pc   <= Redirect_PC & ~32'd3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - CW'(rsp_take);
            discard  <= inflight - CW'(rsp_take);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
            if (q_push)   wr_ptr   <= wr_ptr + PW'(1);
            if (q_pop)    rd_ptr   <= rd_ptr + PW'(1);
            count    <= count + CW'(q_push) - CW'(q_pop);
            inflight <= inflight + CW'(req_fire) - CW'(rsp_take);
            if (rsp_take && (discard != '0)) discard <= discard - CW'(1);
        end
    end

    // Queue storage. Stale words never reach this point because q_push excludes them.
    always_ff @(posedge Clk) begin
        if (q_push) begin
            q_instr[wr_ptr] <= imem.Imem_Rsp_Data;
            q_pc4[wr_ptr]   <= rsp_pc + 32'd4;
        end
    end

    // Head outputs: the queue head, or the bypassed response; zero when nothing is valid.
    always_comb begin
        Instr_Out   = 32'd0;
        PCplus4_Out = 32'd0;
        if (head_valid) begin
            if (count != '0) begin
                Instr_Out   = q_instr[rd_ptr];
                PCplus4_Out = q_pc4[rd_ptr];
            end else begin
                Instr_Out   = imem.Imem_Rsp_Data;
                PCplus4_Out = rsp_pc + 32'd4;
            end
        end
    end

    assign Instr_Valid        = head_valid;
    assign Queue_Count        = count;
    assign imem.Imem_Req_Addr = fetch_pc;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue. A variable-latency, in-order memory
// returns words derived from the request address. A reference model built on
// queues predicts the outputs in every cycle. The model holds the fetch PC,
// the issued-request list with a stale tag for each entry, and the visible
// entries.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst, Stall, Redirect;
    logic [31:0] Redirect_PC;
    logic Instr_Valid;
    logic [31:0] Instr_Out, PCplus4_Out;
    logic [$clog2(DEPTH):0] Queue_Count;

    always #5 Clk = ~Clk;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .imem(bus),
        .Stall(Stall),
        .Redirect(Redirect),
        .Redirect_PC(Redirect_PC),
        .Instr_Valid(Instr_Valid),
        .Instr_Out(Instr_Out),
        .PCplus4_Out(PCplus4_Out),
        .Queue_Count(Queue_Count)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; bit stale; } iss_t;
    typedef struct { logic [31:0] pc4; logic [31:0] instr; } ent_t;

    mreq_t mq[$];      // memory-side accepted requests awaiting a response
    iss_t  m_iss[$];   // model: requests the fetch unit is still waiting for
    ent_t  m_q[$];     // model: entries visible to the ID stage
    logic [31:0] m_pc;
    bit    m_booted;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int mem_last_due = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int spur_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_iss.delete();
        m_pc = RESET_PC & ~32'd3;
        m_booted = 1'b0;
    endtask

    // Runs one clock cycle: drive the inputs, check against the model, then advance the model and the memory.
    task automatic step(input bit rst_n, input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
        bit rsp_v, rsp_take, bypass, exp_rv, exp_iv, consume, mem_pop, obs_rv;
        logic [31:0] exp_instr, exp_pc4, obs_addr;
        iss_t e;
        @(negedge Clk);
        Rst = rst_n;
        bus.Imem_Req_Ready = rdy;
        Stall = stl;
        Redirect = rdr;
        Redirect_PC = rpc;
        mem_pop = (mq.size() > 0) && (mq[0].due <= cyc);
        if (mem_pop) begin
            rsp_v = 1'b1;
            bus.Imem_Rsp_Data = mem_word(mq[0].addr);
        end else begin
            rsp_v = (mq.size() == 0) && ($urandom_range(99) < spur_pct);
            bus.Imem_Rsp_Data = $urandom;
        end
        bus.Imem_Rsp_Valid = rsp_v;

        rsp_take = rsp_v && (m_iss.size() > 0);
        bypass = BYP && rsp_take && (m_q.size() == 0) && !m_iss[0].stale && !rdr;
        exp_rv = m_booted && ((m_q.size() + m_iss.size()) < DEPTH) && !rdr;
        exp_iv = ((m_q.size() > 0) || bypass) && !rdr;
        exp_instr = 32'd0;
        exp_pc4 = 32'd0;
        if (exp_iv) begin
            if (m_q.size() > 0) begin
                exp_instr = m_q[0].instr;
                exp_pc4 = m_q[0].pc4;
            end else begin
                exp_instr = mem_word(m_iss[0].addr);
                exp_pc4 = m_iss[0].addr + 32'd4;
            end
        end

        #2;
        obs_rv = bus.Imem_Req_Valid;
        obs_addr = bus.Imem_Req_Addr;
        check_eq("req_valid", 32'(obs_rv), 32'(exp_rv));
        check_eq("req_addr", obs_addr, m_pc);
        check_eq("instr_valid", 32'(Instr_Valid), 32'(exp_iv));
        check_eq("instr_out", Instr_Out, exp_instr);
        check_eq("pcplus4_out", PCplus4_Out, exp_pc4);
        check_eq("queue_count", 32'(Queue_Count), 32'(m_q.size()));

        @(posedge Clk);
        if (mem_pop) void'(mq.pop_front());
        if (obs_rv && rdy) begin
            int d;
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d <= mem_last_due) d = mem_last_due + 1;
            mq.push_back('{obs_addr, d});
            mem_last_due = d;
        end

        if (!rst_n) begin
            // Orphaned words still come back, back to back, before any new request can be accepted.
            foreach (mq[i]) mq[i].due = cyc + 1 + i;
            mem_last_due = cyc + mq.size();
            model_reset();
        end else if (rdr) begin
            if (rsp_take) void'(m_iss.pop_front());
            foreach (m_iss[i]) m_iss[i].stale = 1'b1;
            m_q.delete();
            m_pc = rpc & ~32'd3;
            m_booted = 1'b1;
        end else begin
            consume = exp_iv && !stl;
            if (consume && (m_q.size() > 0)) void'(m_q.pop_front());
            if (rsp_take) begin
                e = m_iss.pop_front();
                if (!e.stale && !(bypass && consume))
                    m_q.push_back('{e.addr + 32'd4, mem_word(e.addr)});
            end
            if (exp_rv && rdy) begin
                m_iss.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            m_booted = 1'b1;
        end
        cyc++;
    endtask

    task automatic run_rand(input int n, input int rdy_pct, input int stl_pct, input int rdr_pct);
        for (int i = 0; i < n; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
            step(1'b1, $urandom_range(99) < rdy_pct, $urandom_range(99) < stl_pct,
                 $urandom_range(99) < rdr_pct, rpc);
        end
    endtask

    task automatic hold_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        Rst = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        Redirect_PC = 32'd0;
        bus.Imem_Req_Ready = 1'b0;
        bus.Imem_Rsp_Valid = 1'b0;
        bus.Imem_Rsp_Data = 32'd0;
        model_reset();

        hold_reset();
        // Steady stream with a 1-cycle memory
        lat_lo = 1; lat_hi = 1;
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        // Stall long enough to fill the queue, then drain
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        // Three requests in flight at latency 3, then redirect to 0x100
        lat_lo = 3; lat_hi = 3;
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        // Redirect coinciding with a response while Ready is low
        lat_lo = 1; lat_hi = 1;
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0203);
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        // Reset in the middle of a stream with words in flight
        lat_lo = 3; lat_hi = 3;
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        hold_reset();
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        // Random traffic with spurious responses, stalls, redirects and resets
        lat_lo = 1; lat_hi = 4; spur_pct = 20;
        run_rand(3000, 70, 30, 4);
        for (int k = 0; k < 5; k++) begin
            run_rand(400, 60 + 8 * k, 10 * k, 2 + k);
            hold_reset();
        end
        run_rand(200, 90, 20, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
